uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 95 +++++++++
 tb/tb_uart_tx_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locked arbiter feeding one UART transmit path.
// An owner keeps the channel until its last byte moves or it stalls for TIMEOUT cycles.
module uart_tx_arbiter #(
    parameter int REQUESTERS = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [REQUESTERS-1:0]   req_valid,
    input  logic [8*REQUESTERS-1:0] req_data,
    input  logic [REQUESTERS-1:0]   req_last,
    output logic [REQUESTERS-1:0]   req_ready,
    output logic                    tx_valid,
    output logic [7:0]              tx_data,
    input  logic                    tx_ready,
    output logic [REQUESTERS-1:0]   grant,
    output logic                    busy,
    output logic                    timeout_pulse
);
    localparam int IW = $clog2(REQUESTERS);
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t                state_q, state_d;
    logic [IW-1:0]         owner_q, owner_d, ptr_q, ptr_d, win, nxt;
    logic [REQUESTERS-1:0] grant_q, grant_d;
    logic [7:0]            stall_q, stall_d;
    logic                  tmo_q, tmo_d, xfer, any_req;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            grant_q <= '0;
            stall_q <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            stall_q <= stall_d;
            tmo_q   <= tmo_d;
        end
    end
    // Walk downward so the candidate closest above ptr is the one left standing.
    always_comb begin
        win     = ptr_q;
        any_req = 1'b0;
        for (int k = REQUESTERS - 1; k >= 0; k--)
            if (req_valid[(int'(ptr_q) + k) % REQUESTERS]) begin
                win     = IW'((int'(ptr_q) + k) % REQUESTERS);
                any_req = 1'b1;
            end
    end
    assign nxt  = (owner_q == IW'(REQUESTERS - 1)) ? '0 : owner_q + 1'b1;
    assign xfer = (state_q == LOCKED) && req_valid[owner_q] && tx_ready;
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        stall_d = stall_q;
        tmo_d   = 1'b0;
        if (state_q == IDLE) begin
            if (any_req) begin
                state_d = LOCKED;
                owner_d = win;
                grant_d = REQUESTERS'(1) << win;
                stall_d = '0;
            end
        end else if (xfer) begin
            stall_d = '0;
            if (req_last[owner_q]) begin
                state_d = IDLE;
                ptr_d   = nxt;
                grant_d = '0;
            end
        end else if (stall_q == 8'(TIMEOUT)) begin
            state_d = IDLE;
            ptr_d   = nxt;
            grant_d = '0;
            tmo_d   = 1'b1;
        end else begin
            stall_d = stall_q + 8'(stall_q != 8'hff);
        end
    end
    // grant_q is the owner's one-hot while locked, so it doubles as the ready mask.
    always_comb begin
        tx_valid      = (state_q == LOCKED) && req_valid[owner_q];
        tx_data       = (state_q == LOCKED) ? req_data[8*owner_q +: 8] : 8'h00;
        req_ready     = ((state_q == LOCKED) && tx_ready) ? grant_q : '0;
        grant         = grant_q;
        busy          = (state_q == LOCKED);
        timeout_pulse = tmo_q;
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenarios plus randomized traffic checked against a packet-level model.
module tb_uart_tx_arbiter;
    localparam int R = 4;
    logic clk = 1'b0, rst, txr;
    logic [R-1:0] rv, rl;
    logic [8*R-1:0] rd;
    logic [R-1:0] a_rdy, a_grant, b_rdy, b_grant;
    logic a_txv, a_busy, a_tmo, b_txv, b_busy, b_tmo;
    logic [7:0] a_txd, b_txd;
    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.REQUESTERS(R), .TIMEOUT(4)) u4 (
        .clk(clk), .rst(rst), .req_valid(rv), .req_data(rd), .req_last(rl),
        .req_ready(a_rdy), .tx_valid(a_txv), .tx_data(a_txd), .tx_ready(txr),
        .grant(a_grant), .busy(a_busy), .timeout_pulse(a_tmo));

    uart_tx_arbiter #(.REQUESTERS(R), .TIMEOUT(255)) u255 (
        .clk(clk), .rst(rst), .req_valid(rv), .req_data(rd), .req_last(rl),
        .req_ready(b_rdy), .tx_valid(b_txv), .tx_data(b_txd), .tx_ready(txr),
        .grant(b_grant), .busy(b_busy), .timeout_pulse(b_tmo));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; rv = '0; rl = '0; rd = '0; txr = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; rv = '1; rl = '1; txr = 1'b1; rd = 32'h44332211;
        tick();
        #2;
        n_chk++;
        if ({a_grant, a_rdy, a_txv, a_busy, a_tmo} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_a: got %b required 0", {a_grant, a_rdy, a_txv, a_busy, a_tmo});
        end
        n_chk++;
        if ({b_grant, b_rdy, b_txv, b_busy, b_tmo} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_b: got %b required 0", {b_grant, b_rdy, b_txv, b_busy, b_tmo});
        end
    endtask

    task automatic test_round_robin;
        do_reset();
        rv = 4'hf; rl = 4'hf; txr = 1'b1; rd = 32'h44332211;
        for (int i = 0; i < 5; i++) begin
            #2;
            n_chk++;
            if ({a_grant, a_busy, a_txv, a_rdy} !== 10'd0) begin
                n_fail++;
                $display("FAIL rr_idle%0d: got %b required 0", i, {a_grant, a_busy, a_txv, a_rdy});
            end
            tick();
            #2;
            n_chk++;
            if ({a_grant, a_rdy, a_txv, a_busy, a_txd} !== {4'(1 << (i % 4)), 4'(1 << (i % 4)), 2'b11, 8'(8'h11 * (i % 4 + 1))}) begin
                n_fail++;
                $display("FAIL rr_grant%0d: got grant=%b rdy=%b txv=%b data=%h required owner %0d", i, a_grant, a_rdy, a_txv, a_txd, i % 4);
            end
            tick();
        end
    endtask

    task automatic test_packet;
        do_reset();
        txr = 1'b1; rv = 4'b0100; rl = 4'b0001; rd = 32'h00A10055;
        tick();
        rv = 4'b0101;
        for (int k = 0; k < 3; k++) begin
            rd[23:16] = 8'(8'hA1 + k);
            rl[2] = (k == 2);
            #2;
            n_chk++;
            if ({a_grant, a_rdy, a_txv, a_txd} !== {4'b0100, 4'b0100, 1'b1, 8'(8'hA1 + k)}) begin
                n_fail++;
                $display("FAIL pkt_byte%0d: got grant=%b rdy=%b data=%h required 0100/%h", k, a_grant, a_rdy, a_txd, 8'(8'hA1 + k));
            end
            tick();
        end
        #2;
        n_chk++;
        if ({a_grant, a_busy} !== 5'd0) begin
            n_fail++;
            $display("FAIL pkt_gap: got grant=%b busy=%b required idle", a_grant, a_busy);
        end
        tick();
        #2;
        n_chk++;
        if ({a_grant, a_txd} !== {4'b0001, 8'h55}) begin
            n_fail++;
            $display("FAIL pkt_next: got grant=%b data=%h required 0001/55", a_grant, a_txd);
        end
    endtask

    task automatic test_timeout;
        do_reset();
        txr = 1'b1; rv = 4'b0010; rl = '0; rd = 32'h00001100;
        tick();
        #2;
        n_chk++;
        if ({a_grant, a_txv, a_txd} !== {4'b0010, 1'b1, 8'h11}) begin
            n_fail++;
            $display("FAIL to_xfer: got grant=%b txv=%b data=%h required 0010/1/11", a_grant, a_txv, a_txd);
        end
        tick();
        rv = '0;
        for (int c = 1; c <= 5; c++) begin
            #2;
            n_chk++;
            if ({a_grant, a_tmo} !== {4'b0010, 1'b0}) begin
                n_fail++;
                $display("FAIL to_hold%0d: got grant=%b tmo=%b required 0010/0", c, a_grant, a_tmo);
            end
            tick();
        end
        rv = 4'hf;
        #2;
        n_chk++;
        if ({a_grant, a_tmo, a_busy} !== {4'b0000, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL to_revoke: got grant=%b tmo=%b busy=%b required 0000/1/0", a_grant, a_tmo, a_busy);
        end
        tick();
        #2;
        n_chk++;
        if ({a_grant, a_tmo} !== {4'b0100, 1'b0}) begin
            n_fail++;
            $display("FAIL to_next: got grant=%b tmo=%b required 0100/0", a_grant, a_tmo);
        end
    endtask

    task automatic test_stall;
        do_reset();
        txr = 1'b0; rv = 4'b0001; rl = 4'b0001; rd = 32'h0000005A;
        tick();
        for (int c = 0; c < 10; c++) begin
            #2;
            n_chk++;
            if ({b_grant, b_txv, b_txd, b_rdy} !== {4'b0001, 1'b1, 8'h5A, 4'b0000}) begin
                n_fail++;
                $display("FAIL stall%0d: got grant=%b txv=%b data=%h rdy=%b required 0001/1/5a/0000", c, b_grant, b_txv, b_txd, b_rdy);
            end
            tick();
        end
        txr = 1'b1;
        #2;
        n_chk++;
        if (b_rdy !== 4'b0001) begin
            n_fail++;
            $display("FAIL stall_release_rdy: got %b required 0001", b_rdy);
        end
        tick();
        #2;
        n_chk++;
        if ({b_grant, b_busy} !== 5'd0) begin
            n_fail++;
            $display("FAIL stall_done: got grant=%b busy=%b required idle", b_grant, b_busy);
        end
    endtask

    task automatic test_async_reset;
        do_reset();
        txr = 1'b1; rv = 4'b0010; rl = '0; rd = 32'h00007700;
        tick();
        #2;
        n_chk++;
        if (a_grant !== 4'b0010) begin
            n_fail++;
            $display("FAIL arst_pre: got grant=%b required 0010", a_grant);
        end
        rst = 1'b1;
        #1;
        n_chk++;
        if ({a_grant, a_txv, a_busy, b_grant, b_txv, b_busy} !== 12'd0) begin
            n_fail++;
            $display("FAIL arst_now: got %b required 0", {a_grant, a_txv, a_busy, b_grant, b_txv, b_busy});
        end
        rv = 4'hf; rl = 4'hf;
        tick();
        rst = 1'b0;
        #2;
        n_chk++;
        if ({a_grant, a_txv} !== 5'd0) begin
            n_fail++;
            $display("FAIL arst_idle: got grant=%b txv=%b required 0", a_grant, a_txv);
        end
        tick();
        #2;
        n_chk++;
        if (a_grant !== 4'b0001) begin
            n_fail++;
            $display("FAIL arst_restart: got grant=%b required 0001", a_grant);
        end
    endtask

    task automatic test_timeout_tie;
        do_reset();
        txr = 1'b0; rv = 4'b0001; rl = '0; rd = 32'h000000C3;
        tick();
        for (int c = 1; c <= 4; c++) tick();
        txr = 1'b1;
        #2;
        n_chk++;
        if (a_rdy !== 4'b0001) begin
            n_fail++;
            $display("FAIL tie_rdy: got %b required 0001", a_rdy);
        end
        tick();
        txr = 1'b0;
        for (int c = 6; c <= 10; c++) begin
            #2;
            n_chk++;
            if ({a_grant, a_tmo} !== {4'b0001, 1'b0}) begin
                n_fail++;
                $display("FAIL tie_hold%0d: got grant=%b tmo=%b required 0001/0", c, a_grant, a_tmo);
            end
            tick();
        end
        #2;
        n_chk++;
        if ({a_grant, a_tmo} !== {4'b0000, 1'b1}) begin
            n_fail++;
            $display("FAIL tie_revoke: got grant=%b tmo=%b required 0000/1", a_grant, a_tmo);
        end
    endtask

    task automatic test_random;
        bit m_lock, m_tmo, nt;
        int m_own, m_ptr, m_stall, w;
        logic [R-1:0] e_grant, e_rdy;
        bit e_txv;
        do_reset();
        m_lock = 0; m_tmo = 0; m_own = 0; m_ptr = 0; m_stall = 0;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < R; i++) begin
                rv[i] = ($urandom_range(9) < 7);
                rl[i] = ($urandom_range(9) < 3);
            end
            rd = $urandom;
            txr = ($urandom_range(9) < 6);
            e_grant = m_lock ? 4'(1 << m_own) : 4'b0;
            e_txv = m_lock && rv[m_own];
            e_rdy = (m_lock && txr) ? e_grant : 4'b0;
            #2;
            n_chk++;
            if ({a_grant, a_rdy, a_txv, a_busy, a_tmo} !== {e_grant, e_rdy, e_txv, m_lock, m_tmo}) begin
                n_fail++;
                $display("FAIL rand%0d: got g=%b r=%b v=%b b=%b t=%b required g=%b r=%b v=%b b=%b t=%b", n,
                         a_grant, a_rdy, a_txv, a_busy, a_tmo, e_grant, e_rdy, e_txv, m_lock, m_tmo);
            end
            if (e_txv) begin
                n_chk++;
                if (a_txd !== rd[8*m_own +: 8]) begin
                    n_fail++;
                    $display("FAIL rand_data%0d: got %h required %h", n, a_txd, rd[8*m_own +: 8]);
                end
            end
            nt = 0;
            if (!m_lock) begin
                if (rv != 0) begin
                    w = m_ptr;
                    while (!rv[w]) w = (w + 1) % R;
                    m_lock = 1; m_own = w; m_stall = 0;
                end
            end else if (rv[m_own] && txr) begin
                m_stall = 0;
                if (rl[m_own]) begin
                    m_lock = 0; m_ptr = (m_own + 1) % R;
                end
            end else if (m_stall == 4) begin
                m_lock = 0; m_ptr = (m_own + 1) % R; nt = 1;
            end else begin
                m_stall++;
            end
            m_tmo = nt;
            tick();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; rv = '0; rl = '0; rd = '0; txr = 1'b0;
        test_reset();
        test_round_robin();
        test_packet();
        test_timeout();
        test_stall();
        test_async_reset();
        test_timeout_tie();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
